usb2_ulpi_reg_arb: RTL

//  Shares the single ULPI PHY register-access channel (TXCMD RegWrite/RegRead) among
//  NUM_REQ on-chip requesters (link init, HS chirp sequencing, debug/config port).

---
 rtl/usb2_ulpi_reg_arb_if.sv | 37 +++
 rtl/usb2_ulpi_reg_arb.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/usb2_ulpi_reg_arb_if.sv
// Register-access bundle between on-chip requesters, the ULPI register arbiter
// and the ULPI link engine.
interface usb2_ulpi_reg_arb_if #(
  parameter int NUM_REQ = 3
);
  logic [NUM_REQ-1:0]   req_valid;
  logic [NUM_REQ-1:0]   req_we;
  logic [8*NUM_REQ-1:0] req_addr;
  logic [8*NUM_REQ-1:0] req_wdata;
  logic [NUM_REQ-1:0]   req_done;
  logic [NUM_REQ-1:0]   req_err;
  logic [7:0]           req_rdata;
  logic                 phy_dir;
  logic                 pkt_busy;
  logic                 reg_go;
  logic                 reg_we;
  logic [7:0]           reg_addr;
  logic [7:0]           reg_wdata;
  logic                 reg_ack;
  logic                 reg_done;
  logic [7:0]           reg_rdata;
  logic                 busy;

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    input  phy_dir, pkt_busy, reg_ack, reg_done, reg_rdata,
    output req_done, req_err, req_rdata,
    output reg_go, reg_we, reg_addr, reg_wdata, busy
  );

  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    output phy_dir, pkt_busy, reg_ack, reg_done, reg_rdata,
    input  req_done, req_err, req_rdata,
    input  reg_go, reg_we, reg_addr, reg_wdata, busy
  );
endinterface

// File: rtl/usb2_ulpi_reg_arb.sv
// Round-robin arbiter sharing the ULPI PHY register channel among NUM_REQ requesters,
// with PHY-receive preemption before ack and a completion timeout after ack.
module usb2_ulpi_reg_arb #(
  parameter int NUM_REQ     = 3,
  parameter int TIMEOUT_CYC = 255
) (
  input logic                 phy_clk,
  input logic                 reset,
  usb2_ulpi_reg_arb_if.slave  bus
);
  localparam int IDX_W = $clog2(NUM_REQ);
  localparam logic [7:0] TIMEOUT_V = 8'(TIMEOUT_CYC);
  localparam logic [NUM_REQ-1:0] ONEHOT0 = {{(NUM_REQ-1){1'b0}}, 1'b1};
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARM   = 3'd1,
    ST_ISSUE = 3'd2,
    ST_WAIT  = 3'd3,
    ST_DONE  = 3'd4,
    ST_ERR   = 3'd5
  } state_t;

  state_t             state_r, state_s;
  logic [IDX_W-1:0]   grant_r, grant_s;
  logic [IDX_W-1:0]   rr_ptr_r, rr_ptr_s;
  logic [IDX_W-1:0]   pick_s;
  logic [IDX_W-1:0]   rr_next_s;
  logic [7:0]         timer_r, timer_s;
  logic               reg_go_r, reg_go_s;
  logic               reg_we_r, reg_we_s;
  logic [7:0]         reg_addr_r, reg_addr_s;
  logic [7:0]         reg_wdata_r, reg_wdata_s;
  logic [NUM_REQ-1:0] done_r, done_s;
  logic [NUM_REQ-1:0] err_r, err_s;
  logic [7:0]         rdata_r, rdata_s;
  logic               busy_r;

  // First requester at or after ptr, searching cyclically; the doubled vector
  // turns the wrap-around search into a plain shift.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_REQ-1:0] valid,
                                                input logic [IDX_W-1:0]   ptr);
    logic [2*NUM_REQ-1:0] rot;
    logic [IDX_W:0]       idx;
    logic                 found;
    rot     = {valid, valid} >> ptr;
    rr_pick = ptr;
    found   = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found && rot[k]) begin
        found   = 1'b1;
        idx     = {1'b0, ptr} + (IDX_W+1)'(k);
        idx     = (idx >= (IDX_W+1)'(NUM_REQ)) ? idx - (IDX_W+1)'(NUM_REQ) : idx;
        rr_pick = idx[IDX_W-1:0];
      end
    end
  endfunction

  assign pick_s    = rr_pick(bus.req_valid, rr_ptr_r);
  assign rr_next_s = (grant_r == LAST_IDX) ? {IDX_W{1'b0}} : grant_r + IDX_W'(1);

  // Next-state and next-register logic for the arbitration FSM.
  always_comb begin
    state_s     = state_r;
    grant_s     = grant_r;
    rr_ptr_s    = rr_ptr_r;
    timer_s     = timer_r;
    reg_go_s    = reg_go_r;
    reg_we_s    = reg_we_r;
    reg_addr_s  = reg_addr_r;
    reg_wdata_s = reg_wdata_r;
    done_s      = {NUM_REQ{1'b0}};
    err_s       = {NUM_REQ{1'b0}};
    rdata_s     = rdata_r;
    case (state_r)
      ST_IDLE: begin
        if (|bus.req_valid) begin
          grant_s     = pick_s;
          reg_we_s    = bus.req_we[pick_s];
          reg_addr_s  = bus.req_addr[{pick_s, 3'b000} +: 8];
          reg_wdata_s = bus.req_wdata[{pick_s, 3'b000} +: 8];
          state_s     = ST_ARM;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ARM: begin
        if (!bus.phy_dir && !bus.pkt_busy) begin
          reg_go_s = 1'b1;
          state_s  = ST_ISSUE;
        end else begin
          reg_go_s = 1'b0;
        end
      end
      ST_ISSUE: begin
        // An accepted ack wins over a simultaneous bus turnaround.
        if (bus.reg_ack) begin
          reg_go_s = 1'b0;
          timer_s  = 8'd0;
          if (bus.reg_done) begin
            rdata_s = reg_we_r ? rdata_r : bus.reg_rdata;
            done_s  = ONEHOT0 << grant_r;
            state_s = ST_DONE;
          end else begin
            state_s = ST_WAIT;
          end
        end else if (bus.phy_dir) begin
          reg_go_s = 1'b0;
          state_s  = ST_ARM;
        end else begin
          reg_go_s = 1'b1;
        end
      end
      ST_WAIT: begin
        if (bus.reg_done) begin
          rdata_s = reg_we_r ? rdata_r : bus.reg_rdata;
          done_s  = ONEHOT0 << grant_r;
          state_s = ST_DONE;
        end else if (timer_r >= TIMEOUT_V) begin
          err_s   = ONEHOT0 << grant_r;
          state_s = ST_ERR;
        end else begin
          timer_s = timer_r + 8'd1;
        end
      end
      ST_DONE, ST_ERR: begin
        rr_ptr_s = rr_next_s;
        state_s  = ST_IDLE;
      end
      default: begin
        reg_go_s = 1'b0;
        state_s  = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset abandons any in-flight access silently.
  always_ff @(posedge phy_clk or posedge reset) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      grant_r     <= {IDX_W{1'b0}};
      rr_ptr_r    <= {IDX_W{1'b0}};
      timer_r     <= 8'd0;
      reg_go_r    <= 1'b0;
      reg_we_r    <= 1'b0;
      reg_addr_r  <= 8'd0;
      reg_wdata_r <= 8'd0;
      done_r      <= {NUM_REQ{1'b0}};
      err_r       <= {NUM_REQ{1'b0}};
      rdata_r     <= 8'd0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_s;
      grant_r     <= grant_s;
      rr_ptr_r    <= rr_ptr_s;
      timer_r     <= timer_s;
      reg_go_r    <= reg_go_s;
      reg_we_r    <= reg_we_s;
      reg_addr_r  <= reg_addr_s;
      reg_wdata_r <= reg_wdata_s;
      done_r      <= done_s;
      err_r       <= err_s;
      rdata_r     <= rdata_s;
      busy_r      <= (state_s != ST_IDLE);
    end
  end

  assign bus.reg_go    = reg_go_r;
  assign bus.reg_we    = reg_we_r;
  assign bus.reg_addr  = reg_addr_r;
  assign bus.reg_wdata = reg_wdata_r;
  assign bus.req_done  = done_r;
  assign bus.req_err   = err_r;
  assign bus.req_rdata = rdata_r;
  assign bus.busy      = busy_r;
endmodule
